// File: rtl/fnd_button_ctrl.sv
// fnd_button_ctrl: synchronises and debounces three front-panel buttons and
// turns debounced presses into the mode / display-enable levels and a
// one-cycle clear request for the clock/FND top level.
// Optional feature macro: FND_BTN_LONG_PRESS_EN. When defined, the clear
// request fires only after the button has been held for LONG_PRESS_CYCLES;
// when undefined, every debounced clear press yields one pulse.
module fnd_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 200_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_mode,
  input  logic i_btn_onOff,
  input  logic i_btn_clear,
  output logic o_mode,
  output logic o_onOff,
  output logic o_clear_pulse
);

  localparam int unsigned NB      = 3;   // bit 0 mode, bit 1 onOff, bit 2 clear
  localparam int unsigned BTN_M   = 0;
  localparam int unsigned BTN_O   = 1;
  localparam int unsigned BTN_C   = 2;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Both counts must be at least 2 for the counters to be meaningful.
  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
    $error("fnd_button_ctrl: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
  end

  logic [NB-1:0]           sync1_q, sync2_q;
  logic [NB-1:0]           db_q, db_d, db_dly_q, press_q;
  logic [NB-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic                    mode_q, onoff_q, clear_q;

  // Debounce next state: accept a new level only after DEBOUNCE_CYCLES disagreeing samples.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Two-flop synchroniser, debounce registers and registered rising-edge detect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      cnt_q    <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
    end else begin
      sync1_q  <= {i_btn_clear, i_btn_onOff, i_btn_mode};
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
      press_q  <= db_q & ~db_dly_q;
    end
  end

  // Mode and display-enable levels toggle once per debounced press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q  <= 1'b0;
      onoff_q <= 1'b0;
    end else begin
      if (press_q[BTN_M]) mode_q  <= ~mode_q;
      if (press_q[BTN_O]) onoff_q <= ~onoff_q;
    end
  end

`ifdef FND_BTN_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_REL   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FIRED = 2'd2
  } clr_state_e;

  clr_state_e          state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  // Long-press FSM: one clear pulse per hold; the counter stops at its last value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_REL;
      hold_cnt_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        ST_REL: begin
          if (press_q[BTN_C]) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
          end
        end
        ST_HOLD: begin
          if (!db_q[BTN_C]) begin
            state_q <= ST_REL;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= ST_FIRED;
            clear_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_FIRED: begin
          if (!db_q[BTN_C]) state_q <= ST_REL;
        end
        default: state_q <= ST_REL;
      endcase
    end
  end
`else
  // Clear request follows every debounced press, same latency as mode.
  always_ff @(posedge i_clk) begin
    if (i_reset) clear_q <= 1'b0;
    else         clear_q <= press_q[BTN_C];
  end
`endif

  assign o_mode        = mode_q;
  assign o_onOff       = onoff_q;
  assign o_clear_pulse = clear_q;

endmodule

// File: tb/tb_fnd_button_ctrl.sv
// Self-checking bench for fnd_button_ctrl (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10).
// Builds with or without FND_BTN_LONG_PRESS_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_fnd_button_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned LP  = 10;
  localparam int BTN_LAT = DEB + 3;          // raw rise at edge 0 -> toggle at this edge
`ifdef FND_BTN_LONG_PRESS_EN
  localparam int CLR_LAT = DEB + 3 + LP;     // press detect, then LP cycles in HOLD
`else
  localparam int CLR_LAT = DEB + 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bm = 1'b0, bo = 1'b0, bc = 1'b0;
  logic o_mode, o_onOff, o_clear_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  fnd_button_ctrl #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_btn_mode   (bm),
    .i_btn_onOff  (bo),
    .i_btn_clear  (bc),
    .o_mode       (o_mode),
    .o_onOff      (o_onOff),
    .o_clear_pulse(o_clear_pulse)
  );

  // Reference model: a button level is accepted once the value seen two edges
  // after sampling has disagreed with the accepted level for DEB edges in a row.
  // Accepted rises schedule output events at a fixed edge in the future.
  bit [2:0] raw_old1, raw_old2, ref_db;
  int  ref_run [3];
  int  due_mode = -1, due_onoff = -1, due_clear = -1;
  bit  exp_mode, exp_onoff, exp_clear;

  always @(posedge clk) begin
    bit [2:0] raw;
    bit [2:0] seen;
    edge_cnt++;
    raw = {bc, bo, bm};
    if (rst) begin
      raw_old1 = '0; raw_old2 = '0; ref_db = '0;
      for (int i = 0; i < 3; i++) ref_run[i] = 0;
      due_mode = -1; due_onoff = -1; due_clear = -1;
      exp_mode = 1'b0; exp_onoff = 1'b0; exp_clear = 1'b0;
    end else begin
      if (due_mode  == edge_cnt) exp_mode  = ~exp_mode;
      if (due_onoff == edge_cnt) exp_onoff = ~exp_onoff;
      exp_clear = (due_clear == edge_cnt);
      seen = raw_old2;
      for (int i = 0; i < 3; i++) begin
        if (seen[i] != ref_db[i]) begin
          ref_run[i]++;
          if (ref_run[i] == int'(DEB)) begin
            ref_db[i] = seen[i];
            ref_run[i] = 0;
            if (seen[i]) begin
              if (i == 0) due_mode  = edge_cnt + 2;
              if (i == 1) due_onoff = edge_cnt + 2;
              if (i == 2) due_clear = edge_cnt + 2 + (CLR_LAT - BTN_LAT);
            end else begin
`ifdef FND_BTN_LONG_PRESS_EN
              // released before the hold time completed: no pulse
              if (i == 2 && due_clear > edge_cnt) due_clear = -1;
`endif
            end
          end
        end else begin
          ref_run[i] = 0;
        end
      end
      raw_old2 = raw_old1;
      raw_old1 = raw;
    end
  end

  task automatic apply_reset();
    rst = 1'b1; bm = 1'b0; bo = 1'b0; bc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int start;
    int rise_at = -1;
    rst = 1'b1; bm = 1'b1; bo = 1'b1; bc = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({o_mode, o_onOff, o_clear_pulse} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_state: got %b, expected 000", {o_mode, o_onOff, o_clear_pulse});
      end
    end
    rst = 1'b0;
    start = edge_cnt + 1;
    repeat (12) begin
      @(negedge clk);
      n_tests++;
      if ({o_mode, o_onOff, o_clear_pulse} !== {exp_mode, exp_onoff, exp_clear}) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b, expected %b", edge_cnt,
                 {o_mode, o_onOff, o_clear_pulse}, {exp_mode, exp_onoff, exp_clear});
      end
      if (o_mode === 1'b1 && rise_at < 0) rise_at = edge_cnt;
    end
    n_tests++;
    if (rise_at !== start + BTN_LAT) begin
      n_fail++;
      $display("FAIL reset_release_latency: got edge %0d, expected %0d", rise_at - start, BTN_LAT);
    end
  endtask

  task automatic test_clean_press();
    int start;
    int rise_at = -1;
    int fall_at = -1;
    apply_reset();
    bm = 1'b1;
    start = edge_cnt + 1;
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if ({o_mode, o_onOff, o_clear_pulse} !== {exp_mode, exp_onoff, exp_clear}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got %b, expected %b", edge_cnt,
                 {o_mode, o_onOff, o_clear_pulse}, {exp_mode, exp_onoff, exp_clear});
      end
      if (o_mode === 1'b1 && rise_at < 0) rise_at = edge_cnt;
    end
    n_tests++;
    if (rise_at !== start + BTN_LAT || o_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_press_toggle: got edge %0d mode %b, expected edge %0d mode 1",
               rise_at - start, o_mode, BTN_LAT);
    end
    bm = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (o_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL release_no_toggle: got mode %b, expected 1", o_mode);
    end
    bm = 1'b1;
    start = edge_cnt + 1;
    repeat (20) begin
      @(negedge clk);
      if (o_mode === 1'b0 && fall_at < 0) fall_at = edge_cnt;
    end
    n_tests++;
    if (fall_at !== start + BTN_LAT || o_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL second_press_toggle: got edge %0d mode %b, expected edge %0d mode 0",
               fall_at - start, o_mode, BTN_LAT);
    end
  endtask

  task automatic test_bounce();
    bit pattern [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int start;
    int rises = 0;
    int rise_at = -1;
    bit prev;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      bo = pattern[k];
      @(negedge clk);
      n_tests++;
      if (o_onOff !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_hold_off step %0d: got %b, expected 0", k, o_onOff);
      end
    end
    bo = 1'b1;
    start = edge_cnt + 1;
    prev = o_onOff;
    repeat (15) begin
      @(negedge clk);
      n_tests++;
      if ({o_mode, o_onOff, o_clear_pulse} !== {exp_mode, exp_onoff, exp_clear}) begin
        n_fail++;
        $display("FAIL bounce_steady edge %0d: got %b, expected %b", edge_cnt,
                 {o_mode, o_onOff, o_clear_pulse}, {exp_mode, exp_onoff, exp_clear});
      end
      if (o_onOff === 1'b1 && prev === 1'b0) begin
        rises++;
        if (rise_at < 0) rise_at = edge_cnt;
      end
      prev = o_onOff;
    end
    n_tests++;
    if (rises !== 1 || rise_at !== start + BTN_LAT) begin
      n_fail++;
      $display("FAIL bounce_single_toggle: got %0d toggles at edge %0d, expected 1 at %0d",
               rises, rise_at - start, BTN_LAT);
    end
  endtask

  task automatic test_simultaneous();
    int start;
    int m_at = -1;
    int o_at = -1;
    apply_reset();
    bm = 1'b1; bo = 1'b1;
    start = edge_cnt + 1;
    repeat (12) begin
      @(negedge clk);
      if (o_mode === 1'b1 && m_at < 0) m_at = edge_cnt;
      if (o_onOff === 1'b1 && o_at < 0) o_at = edge_cnt;
    end
    n_tests++;
    if (m_at !== start + BTN_LAT || o_at !== start + BTN_LAT) begin
      n_fail++;
      $display("FAIL simultaneous: got mode edge %0d onOff edge %0d, expected both %0d",
               m_at - start, o_at - start, BTN_LAT);
    end
  endtask

  task automatic test_long_press();
    int start;
    int pulses = 0;
    int first_at = -1;
    apply_reset();
    bc = 1'b1;
    start = edge_cnt + 1;
    for (int k = 0; k < 45; k++) begin
      if (k == 30) bc = 1'b0;
      @(negedge clk);
      if (o_clear_pulse === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = edge_cnt;
      end
    end
    n_tests++;
    if (pulses !== 1 || first_at !== start + CLR_LAT) begin
      n_fail++;
      $display("FAIL hold30: got %0d pulses first at edge %0d, expected 1 at %0d",
               pulses, first_at - start, CLR_LAT);
    end
    pulses = 0; first_at = -1;
    bc = 1'b1;
    start = edge_cnt + 1;
    for (int k = 0; k < 30; k++) begin
      if (k == 8) bc = 1'b0;
      @(negedge clk);
      if (o_clear_pulse === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = edge_cnt;
      end
    end
`ifdef FND_BTN_LONG_PRESS_EN
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL hold8_no_pulse: got %0d pulses, expected 0", pulses);
    end
`else
    n_tests++;
    if (pulses !== 1 || first_at !== start + BTN_LAT) begin
      n_fail++;
      $display("FAIL hold8_pulse: got %0d pulses first at edge %0d, expected 1 at %0d",
               pulses, first_at - start, BTN_LAT);
    end
`endif
  endtask

  task automatic test_reset_mid_hold();
    int start;
    int early = 0;
    int pulses = 0;
    int first_at = -1;
    apply_reset();
    bc = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_clear_pulse === 1'b1) early++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (o_clear_pulse === 1'b1) early++;
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL mid_hold_early_pulse: got %0d pulses, expected 0", early);
    end
    rst = 1'b0;
    start = edge_cnt + 1;
    repeat (25) begin
      @(negedge clk);
      if (o_clear_pulse === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = edge_cnt;
      end
    end
    n_tests++;
    if (pulses !== 1 || first_at !== start + CLR_LAT) begin
      n_fail++;
      $display("FAIL mid_hold_repress: got %0d pulses first at edge %0d, expected 1 at %0d",
               pulses, first_at - start, CLR_LAT);
    end
    bc = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    repeat (600) begin
      if ($urandom_range(5, 0) == 0) bm = ~bm;
      if ($urandom_range(5, 0) == 0) bo = ~bo;
      if ($urandom_range(7, 0) == 0) bc = ~bc;
      rst = ($urandom_range(149, 0) == 0);
      @(negedge clk);
      n_tests++;
      if ({o_mode, o_onOff, o_clear_pulse} !== {exp_mode, exp_onoff, exp_clear}) begin
        n_fail++;
        $display("FAIL random edge %0d: got %b, expected %b", edge_cnt,
                 {o_mode, o_onOff, o_clear_pulse}, {exp_mode, exp_onoff, exp_clear});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_long_press();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
